// File: rtl/yacht_pkg.sv
// yacht_pkg
// Shared definitions for the Yacht Dice datapath: die geometry, the blank
// face code, the LFSR feedback polynomial, the dice engine FSM encoding and
// the byte-to-face mapping also used by the score calculator tests.
package yacht_pkg;

  localparam int          NUM_DICE   = 5;
  localparam int          DIE_W      = 3;
  localparam logic [2:0]  FACE_BLANK = 3'd0;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } roll_state_t;

  // Scales a uniform byte onto 1..6. The product needs 11 bits (255*6=1530),
  // and its top three bits are 0..5, so the face never leaves 1..6.
  function automatic logic [DIE_W-1:0] face_map(input logic [7:0] rnd);
    logic [10:0] prod;
    prod = {3'b000, rnd} * 11'd6;
    return prod[10:8] + 3'd1;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// lfsr32
// Free-running 32-bit Galois LFSR (right-shifting form). A zero seed would
// lock the register at zero, so it is replaced by 1.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, loads the seed
//   en       in   advance enable
//   state    out  current 32-bit LFSR state
module lfsr32
  import yacht_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001,
  parameter logic [31:0] POLY = LFSR_POLY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [31:0] state
);

  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED_NZ;
    end else if (en) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? POLY : 32'h0);
    end
  end

endmodule

// File: rtl/dice_roll_unit.sv
// dice_roll_unit
// Dice engine for Yacht Dice. On a roll request it animates the non-held dice
// for ANIM_STEPS steps of TICK_CYCLES clocks each, then commits the final
// faces and pulses roll_done. new_turn clears the dice and the roll count.
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   roll_trigger  in   one-cycle roll request
//   new_turn      in   one-cycle turn-start pulse, clears dice and holds
//   hold_sw       in   per-die hold request (bit i = die i)
//   dice          out  packed faces, die i at [3i+2:3i], 0 = blank
//   dice_valid    out  dice hold a committed roll of the current turn
//   busy          out  high while animating
//   roll_done     out  one-cycle pulse when final faces are committed
//   roll_count    out  completed rolls this turn, saturating at 3
module dice_roll_unit
  import yacht_pkg::*;
#(
  parameter int          ANIM_STEPS  = 8,
  parameter int          TICK_CYCLES = 2_500_000,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        roll_trigger,
  input  logic        new_turn,
  input  logic [4:0]  hold_sw,
  output logic [14:0] dice,
  output logic        dice_valid,
  output logic        busy,
  output logic        roll_done,
  output logic [1:0]  roll_count
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int STEP_W = (ANIM_STEPS > 1) ? $clog2(ANIM_STEPS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ANIM_STEPS - 1);

  roll_state_t       state;
  logic [31:0]       lfsr;
  logic [TICK_W-1:0] tick_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [4:0]        hold_mask;

  lfsr32 #(
    .SEED(LFSR_SEED),
    .POLY(LFSR_POLY)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (1'b1),
    .state  (lfsr)
  );

  // Dice 0..3 take one LFSR byte each; die 4 folds the top and bottom bytes
  // together so it is not a plain copy of any other die.
  function automatic logic [7:0] die_byte(input logic [31:0] s, input int idx);
    if (idx == NUM_DICE - 1) begin
      return s[31:24] ^ s[7:0];
    end
    return s[idx*8 +: 8];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dice       <= '0;
      dice_valid <= 1'b0;
      busy       <= 1'b0;
      roll_done  <= 1'b0;
      roll_count <= 2'd0;
      tick_cnt   <= '0;
      step_cnt   <= '0;
      hold_mask  <= 5'b00000;
    end else begin
      roll_done <= 1'b0;
      // new_turn wins over everything, including a roll in flight.
      if (new_turn) begin
        state      <= IDLE;
        busy       <= 1'b0;
        dice       <= '0;
        dice_valid <= 1'b0;
        roll_count <= 2'd0;
        tick_cnt   <= '0;
        step_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (roll_trigger) begin
              // Holds only make sense once there is a committed roll.
              hold_mask <= dice_valid ? hold_sw : 5'b00000;
              tick_cnt  <= '0;
              step_cnt  <= '0;
              state     <= ROLL;
              busy      <= 1'b1;
            end
          end
          ROLL: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              for (int i = 0; i < NUM_DICE; i++) begin
                if (!hold_mask[i]) begin
                  dice[i*DIE_W +: DIE_W] <= face_map(die_byte(lfsr, i));
                end
              end
              if (step_cnt == STEP_LAST) begin
                state      <= IDLE;
                busy       <= 1'b0;
                roll_done  <= 1'b1;
                dice_valid <= 1'b1;
                if (roll_count != 2'd3) begin
                  roll_count <= roll_count + 2'd1;
                end
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dice_roll_unit.sv
// tb_dice_roll_unit
// Self-checking bench for dice_roll_unit with TICK_CYCLES=2, ANIM_STEPS=3.
// A reference LFSR and die model predict every animation step from the
// published rules; each scenario task compares the DUT against it.
module tb_dice_roll_unit;

  localparam int          TICK = 2;
  localparam int          ANIM = 3;
  localparam int          ROLL_CYCLES = TICK * ANIM;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam int          RAND_ROLLS = 3000;

  logic        clk;
  logic        reset_n;
  logic        roll_trigger;
  logic        new_turn;
  logic [4:0]  hold_sw;
  logic [14:0] dice;
  logic        dice_valid;
  logic        busy;
  logic        roll_done;
  logic [1:0]  roll_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_lfsr;
  logic [14:0] m_dice;
  logic        m_valid;
  int          m_count;
  logic [4:0]  last_eff;

  // Observations captured by drive_roll
  logic [14:0] step_obs [1:ANIM];
  logic [14:0] step_exp [1:ANIM];
  logic        busy_t1;
  int          busy_gaps;
  int          roll_pulses;
  int          roll_done_at;
  logic        final_busy;
  logic        final_valid;
  logic [1:0]  final_count;
  logic        done_after;
  logic [14:0] dice_after;

  dice_roll_unit #(
    .ANIM_STEPS (ANIM),
    .TICK_CYCLES(TICK),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .roll_trigger(roll_trigger),
    .new_turn    (new_turn),
    .hold_sw     (hold_sw),
    .dice        (dice),
    .dice_valid  (dice_valid),
    .busy        (busy),
    .roll_done   (roll_done),
    .roll_count  (roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: right-shifting Galois register, stepped every clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= SEED;
    else          m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'h0);
  end

  // New dice after one animation step, using plain arithmetic on the bytes.
  function automatic logic [14:0] next_dice(input logic [31:0] s, input logic [14:0] cur,
                                            input logic [4:0] hold);
    logic [14:0] r;
    int b;
    r = cur;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) b = int'((s >> (8 * i)) & 32'hFF);
      else       b = int'(((s >> 24) ^ s) & 32'hFF);
      if (!hold[i]) r[3*i +: 3] = 3'((b * 6) / 256 + 1);
    end
    return r;
  endfunction

  // Issues one roll and records what the DUT does every cycle until one
  // cycle after completion; the model advances alongside it.
  task automatic drive_roll(input logic [4:0] hold);
    last_eff = m_valid ? hold : 5'b00000;
    roll_pulses = 0;
    roll_done_at = -1;
    busy_gaps = 0;
    @(negedge clk);
    roll_trigger = 1'b1;
    hold_sw = hold;
    @(negedge clk);
    roll_trigger = 1'b0;
    busy_t1 = busy;
    hold_sw = 5'($urandom);
    for (int j = 1; j <= ROLL_CYCLES; j++) begin
      if (j % TICK == 0) begin
        m_dice = next_dice(m_lfsr, m_dice, last_eff);
        step_exp[j / TICK] = m_dice;
      end
      @(negedge clk);
      if (roll_done === 1'b1) begin
        roll_pulses++;
        roll_done_at = j;
      end
      if (j % TICK == 0) step_obs[j / TICK] = dice;
      if (j < ROLL_CYCLES && busy !== 1'b1) busy_gaps++;
    end
    final_busy  = busy;
    final_valid = dice_valid;
    final_count = roll_count;
    m_valid = 1'b1;
    if (m_count < 3) m_count++;
    @(negedge clk);
    done_after = roll_done;
    dice_after = dice;
  endtask

  task automatic test_reset;
    checks++; if (dice !== 15'd0) begin errors++; $display("[TB] FAIL reset_dice: got %h expected 0", dice); end
    checks++; if (dice_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", dice_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (roll_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", roll_done); end
    checks++; if (roll_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", roll_count); end
  endtask

  task automatic test_first_roll;
    drive_roll(5'h1F);
    checks++; if (busy_t1 !== 1'b1) begin errors++; $display("[TB] FAIL first_busy_t1: got %b expected 1", busy_t1); end
    for (int k = 1; k <= ANIM; k++) begin
      checks++;
      if (step_obs[k] !== step_exp[k]) begin
        errors++; $display("[TB] FAIL first_step%0d: got %h expected %h", k, step_obs[k], step_exp[k]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (step_obs[1][3*i +: 3] === 3'd0) begin
        errors++; $display("[TB] FAIL first_die%0d_updated: got 0 expected nonzero", i);
      end
    end
    checks++; if (roll_pulses != 1) begin errors++; $display("[TB] FAIL first_pulses: got %0d expected 1", roll_pulses); end
    checks++; if (roll_done_at != ROLL_CYCLES) begin errors++; $display("[TB] FAIL first_done_at: got %0d expected %0d", roll_done_at, ROLL_CYCLES); end
    checks++; if (busy_gaps != 0) begin errors++; $display("[TB] FAIL first_busy_gaps: got %0d expected 0", busy_gaps); end
    checks++; if (final_busy !== 1'b0) begin errors++; $display("[TB] FAIL first_busy_end: got %b expected 0", final_busy); end
    checks++; if (final_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1", final_valid); end
    checks++; if (final_count !== 2'd1) begin errors++; $display("[TB] FAIL first_count: got %0d expected 1", final_count); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("[TB] FAIL first_done_len: got %b expected 0", done_after); end
    checks++; if (dice_after !== step_exp[ANIM]) begin errors++; $display("[TB] FAIL first_stable: got %h expected %h", dice_after, step_exp[ANIM]); end
  endtask

  task automatic test_hold_roll;
    logic [14:0] prev;
    prev = m_dice;
    drive_roll(5'b00101);
    for (int k = 1; k <= ANIM; k++) begin
      checks++;
      if (step_obs[k][2:0] !== prev[2:0] || step_obs[k][8:6] !== prev[8:6]) begin
        errors++; $display("[TB] FAIL hold_step%0d: got %h expected held dice from %h", k, step_obs[k], prev);
      end
      checks++;
      if (step_obs[k] !== step_exp[k]) begin
        errors++; $display("[TB] FAIL hold_value%0d: got %h expected %h", k, step_obs[k], step_exp[k]);
      end
    end
    checks++; if (roll_pulses != 1) begin errors++; $display("[TB] FAIL hold_pulses: got %0d expected 1", roll_pulses); end
    checks++; if (final_count !== 2'd2) begin errors++; $display("[TB] FAIL hold_count: got %0d expected 2", final_count); end
  endtask

  task automatic test_new_turn_mid_roll;
    int pulses;
    int nonblank;
    @(negedge clk);
    roll_trigger = 1'b1;
    hold_sw = 5'h00;
    @(negedge clk);
    roll_trigger = 1'b0;
    @(negedge clk);
    @(negedge clk);
    new_turn = 1'b1;
    @(negedge clk);
    new_turn = 1'b0;
    m_dice = 15'd0; m_valid = 1'b0; m_count = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nt_busy: got %b expected 0", busy); end
    checks++; if (dice !== 15'd0) begin errors++; $display("[TB] FAIL nt_dice: got %h expected 0", dice); end
    checks++; if (dice_valid !== 1'b0) begin errors++; $display("[TB] FAIL nt_valid: got %b expected 0", dice_valid); end
    checks++; if (roll_count !== 2'd0) begin errors++; $display("[TB] FAIL nt_count: got %0d expected 0", roll_count); end
    pulses = 0;
    nonblank = 0;
    for (int j = 0; j < 12; j++) begin
      if (roll_done === 1'b1) pulses++;
      if (dice !== 15'd0) nonblank++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL nt_no_done: got %0d pulses expected 0", pulses); end
    checks++; if (nonblank != 0) begin errors++; $display("[TB] FAIL nt_dice_stay: got %0d nonblank cycles expected 0", nonblank); end
  endtask

  task automatic test_new_turn_priority;
    @(negedge clk);
    new_turn = 1'b1;
    roll_trigger = 1'b1;
    hold_sw = 5'($urandom);
    @(negedge clk);
    new_turn = 1'b0;
    roll_trigger = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_busy: got %b expected 0", busy); end
    checks++; if (dice_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_valid: got %b expected 0", dice_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_no_roll: got %b expected 0", busy); end
    drive_roll(5'($urandom));
    checks++; if (roll_pulses != 1 || roll_done_at != ROLL_CYCLES) begin
      errors++; $display("[TB] FAIL prio_roll_done: got %0d pulses at %0d expected 1 at %0d", roll_pulses, roll_done_at, ROLL_CYCLES);
    end
    checks++; if (step_obs[ANIM] !== step_exp[ANIM]) begin errors++; $display("[TB] FAIL prio_dice: got %h expected %h", step_obs[ANIM], step_exp[ANIM]); end
    checks++; if (final_count !== 2'd1) begin errors++; $display("[TB] FAIL prio_count: got %0d expected 1", final_count); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    int done_at;
    logic [4:0] eff;
    eff = m_valid ? 5'b10010 : 5'b00000;
    pulses = 0;
    done_at = -1;
    @(negedge clk);
    roll_trigger = 1'b1;
    hold_sw = 5'b10010;
    @(negedge clk);
    roll_trigger = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      roll_trigger = (j == 2 || j == 4);
      if (j % TICK == 0 && j <= ROLL_CYCLES) m_dice = next_dice(m_lfsr, m_dice, eff);
      @(negedge clk);
      if (roll_done === 1'b1) begin
        pulses++;
        done_at = j;
      end
    end
    roll_trigger = 1'b0;
    m_valid = 1'b1;
    if (m_count < 3) m_count++;
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 1", pulses); end
    checks++; if (done_at != ROLL_CYCLES) begin errors++; $display("[TB] FAIL b2b_done_at: got %0d expected %0d", done_at, ROLL_CYCLES); end
    checks++; if (dice !== m_dice) begin errors++; $display("[TB] FAIL b2b_dice: got %h expected %h", dice, m_dice); end
    checks++; if (roll_count !== 2'(m_count)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", roll_count, m_count); end
  endtask

  task automatic test_random_rolls;
    int hist [0:4][0:6];
    int tot [0:4];
    int face;
    int bad_range;
    int lo;
    int hi;
    for (int i = 0; i < 5; i++) begin
      tot[i] = 0;
      for (int f = 0; f <= 6; f++) hist[i][f] = 0;
    end
    for (int r = 0; r < RAND_ROLLS; r++) begin
      drive_roll(5'($urandom) & 5'($urandom));
      for (int k = 1; k <= ANIM; k++) begin
        checks++;
        if (step_obs[k] !== step_exp[k]) begin
          errors++; $display("[TB] FAIL rand_r%0d_step%0d: got %h expected %h", r, k, step_obs[k], step_exp[k]);
        end
        bad_range = 0;
        for (int i = 0; i < 5; i++) begin
          face = int'(step_obs[k][3*i +: 3]);
          if (face < 1 || face > 6) bad_range++;
          if (!last_eff[i]) begin
            hist[i][face]++;
            tot[i]++;
          end
        end
        checks++;
        if (bad_range != 0) begin
          errors++; $display("[TB] FAIL rand_range_r%0d_step%0d: got %h expected all faces in 1..6", r, k, step_obs[k]);
        end
      end
      checks++;
      if (roll_pulses != 1 || final_count !== 2'(m_count)) begin
        errors++; $display("[TB] FAIL rand_done_r%0d: got %0d pulses count %0d expected 1 pulse count %0d", r, roll_pulses, final_count, m_count);
      end
    end
    checks++; if (roll_count !== 2'd3) begin errors++; $display("[TB] FAIL rand_saturate: got %0d expected 3", roll_count); end
    for (int i = 0; i < 5; i++) begin
      lo = tot[i] * 9 / 60;
      hi = tot[i] * 11 / 60;
      for (int f = 1; f <= 6; f++) begin
        checks++;
        if (hist[i][f] < lo || hist[i][f] > hi) begin
          errors++; $display("[TB] FAIL hist_die%0d_face%0d: got %0d expected %0d..%0d", i, f, hist[i][f], lo, hi);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    roll_trigger = 1'b0;
    new_turn = 1'b0;
    hold_sw = 5'b00000;
    m_dice = 15'd0;
    m_valid = 1'b0;
    m_count = 0;
    last_eff = 5'b00000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    $display("[TB] starting dice_roll_unit bench");
    test_reset();
    test_first_roll();
    test_hold_roll();
    test_new_turn_mid_roll();
    test_new_turn_priority();
    test_back_to_back();
    test_random_rolls();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
